// File: rtl/si_sample_sink.sv
// SI bus slave endpoint: edge-triggered command FSM, 64x32 sample RAM,
// control/status register bank and an independent consumer read port.
module si_sample_sink #(
  parameter int SAMPLE_WORDS = 64,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exec,
  input  logic        we,
  input  logic [8:0]  si_address,
  input  logic [31:0] si_data,
  output logic        fin,
  output logic [31:0] si_rdata,
  input  logic [5:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_WR_COUNT  = 8'h04;
  localparam logic [7:0] REG_ERR_COUNT = 8'h08;
  localparam logic [7:0] REG_SCRATCH   = 8'h0C;
  localparam logic [CNT_W-1:0] WR_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WR_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic              exec_q_r;
  logic              cmd_we_r;
  logic [8:0]        cmd_addr_r;
  logic [31:0]       cmd_data_r;
  logic              enable_r;
  logic [CNT_W-1:0]  wr_count_r;
  logic [7:0]        err_count_r;
  logic [31:0]       scratch_r;
  logic [31:0]       mem [SAMPLE_WORDS];

  logic              start_s;
  logic              aligned_s;
  logic [5:0]        idx_s;
  logic              ram_we_s;
  logic              frame_s;
  logic              err_inc_s;
  logic              err_clr_s;
  logic              wr_clr_s;
  logic              ctrl_we_s;
  logic              scratch_we_s;
  logic [31:0]       acc_rdata_s;

  assign start_s = exec & ~exec_q_r;

  // Decode the captured command; results are only acted on in ACCESS.
  always_comb begin
    aligned_s    = (cmd_addr_r[1:0] == 2'b00);
    idx_s        = cmd_addr_r[7:2];
    ram_we_s     = 1'b0;
    err_inc_s    = 1'b0;
    err_clr_s    = 1'b0;
    wr_clr_s     = 1'b0;
    ctrl_we_s    = 1'b0;
    scratch_we_s = 1'b0;
    acc_rdata_s  = 32'h0000_0000;
    if (cmd_addr_r[8]) begin
      // misaligned sample accesses never touch the RAM and read as zero
      if (!aligned_s) begin
        err_inc_s = 1'b1;
      end else if (cmd_we_r) begin
        if (enable_r) begin
          ram_we_s = 1'b1;
        end else begin
          err_inc_s = 1'b1;
        end
      end else begin
        acc_rdata_s = mem[idx_s];
      end
    end else begin
      case (cmd_addr_r[7:0])
        REG_CTRL: begin
          if (cmd_we_r) begin
            ctrl_we_s = 1'b1;
          end else begin
            acc_rdata_s = {31'h0000_0000, enable_r};
          end
        end
        REG_WR_COUNT: begin
          if (cmd_we_r) begin
            wr_clr_s = 1'b1;
          end else begin
            acc_rdata_s = 32'(wr_count_r);
          end
        end
        REG_ERR_COUNT: begin
          if (cmd_we_r) begin
            err_clr_s = 1'b1;
          end else begin
            acc_rdata_s = {24'h00_0000, err_count_r};
          end
        end
        REG_SCRATCH: begin
          if (cmd_we_r) begin
            scratch_we_s = 1'b1;
          end else begin
            acc_rdata_s = scratch_r;
          end
        end
        default: begin
          if (cmd_we_r) begin
            err_inc_s = 1'b1;
          end else begin
            acc_rdata_s = 32'h0000_0000;
          end
        end
      endcase
    end
    frame_s = ram_we_s && (idx_s == 6'd63);
  end

  // Command FSM, register bank and registered SI outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      exec_q_r    <= 1'b0;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= 9'h000;
      cmd_data_r  <= 32'h0000_0000;
      enable_r    <= 1'b1;
      wr_count_r  <= {CNT_W{1'b0}};
      err_count_r <= 8'h00;
      scratch_r   <= 32'h0000_0000;
      fin         <= 1'b0;
      si_rdata    <= 32'h0000_0000;
      frame_done  <= 1'b0;
    end else begin
      exec_q_r   <= exec;
      fin        <= 1'b0;
      si_rdata   <= 32'h0000_0000;
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            cmd_we_r   <= we;
            cmd_addr_r <= si_address;
            cmd_data_r <= si_data;
            state_r    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_r    <= ST_ACK;
          fin        <= 1'b1;
          si_rdata   <= acc_rdata_s;
          frame_done <= frame_s;
          if (ctrl_we_s) begin
            enable_r <= cmd_data_r[0];
          end
          if (scratch_we_s) begin
            scratch_r <= cmd_data_r;
          end
          if (wr_clr_s) begin
            wr_count_r <= {CNT_W{1'b0}};
          end else if (ram_we_s && (wr_count_r != WR_MAX)) begin
            wr_count_r <= wr_count_r + WR_ONE;
          end
          if (err_clr_s) begin
            err_count_r <= 8'h00;
          end else if (err_inc_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
          end
        end
        ST_ACK: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_ACCESS) && ram_we_s) begin
      mem[idx_s] <= cmd_data_r;
    end
  end

  // Consumer read port: sees pre-write data when a write commits on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= 32'h0000_0000;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: doc/si_sample_sink.md
# si_sample_sink

Slave-side endpoint of the simple-interface (SI) bus. It consumes `exec`/`we`/`si_address`/`si_data` write and read commands issued by the sine/ADC sample driver, and stores sample words in a 64 x 32 sample RAM. Commands are acknowledged with a one-cycle `fin` pulse, and a small register bank provides control and status. A read-only consumer port exposes the RAM to the downstream DSP stage.

## Interface
- `SAMPLE_WORDS`, 64: sample RAM depth in 32-bit words. Must equal 2^(address bits [7:2]).
- `CNT_W`, 16: width of the saturating write counter.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `exec`  in  1  command strobe; only a rising edge starts a command.
- `we`  in  1  1 = write, 0 = read; sampled with `exec`.
- `si_address`  in  9  byte address; bit 8 selects the sample region (1) or the register region (0).
- `si_data`  in  32  write data; sampled with `exec`.
- `fin`  out  1  one-cycle acknowledge per accepted command.
- `si_rdata`  out  32  read data; valid while `fin`=1.
- `rd_addr`  in  6  consumer word index.
- `rd_data`  out  32  sample RAM word at `rd_addr`, one cycle later.
- `frame_done`  out  1  one-cycle pulse when word 63 is written.

## Operation
- Edge detect: `start = exec & !exec_q`, where `exec_q` is registered. `exec` held high does not repeat a command.
- FSM states:
  - IDLE: on `start`, capture `we`, `si_address` and `si_data`, then go to ACCESS. A `start` seen in ACCESS or ACK is dropped; no queueing.
  - ACCESS: perform the access, then go to ACK.
  - ACK: `fin`=1, then go to IDLE.
- Sample region (addr[8]=1):
  - Word index = addr[7:2].
  - addr[1:0]≠0 is misaligned: the write is not performed, `err_count` increments, `fin` is still issued, and `si_rdata`=0.
  - Write with `enable`=1: store the word and increment `wr_count` (saturates at all-ones).
  - Write to index 63: pulse `frame_done` in the ACK cycle.
  - Write with `enable`=0: dropped, `err_count` increments.
  - Read: returns the stored word.
- Register region (addr[8]=0), word-aligned:
  - 0x000 CTRL, RW: bit0 = `enable`, reset value 1; other bits read 0.
  - 0x004 WR_COUNT, RO: write to it clears it to 0.
  - 0x008 ERR_COUNT, RO: 8-bit, saturating at 255; write to it clears it to 0.
  - 0x00C SCRATCH, RW: 32-bit, reset value 0.
  - Any other address: reads return 0; writes are ignored and increment `err_count`.
- Consumer port is independent of the FSM: `rd_data` ← RAM[`rd_addr`] every cycle.
  - If a write to the same word commits on the same edge, `rd_data` shows the old data (read-before-write). The new value appears on the next cycle.
- The sample RAM is not cleared by reset. Its contents are undefined until written.

## Timing
- `start` sampled at edge E0 → ACCESS during E0..E1. The write commits at E1. `fin`=1 and `si_rdata` are valid during E1..E2. The FSM is back in IDLE at E2.
- Latency from the `exec` rise being sampled to `fin`: 2 cycles. Maximum command rate: one per 3 cycles.
- Reset values:
  - `fin`=0, `si_rdata`=0, `rd_data`=0, `frame_done`=0.
  - FSM=IDLE, `exec_q`=0, `enable`=1, `wr_count`=0, `err_count`=0, `scratch`=0.
- Reset asserted mid-command: the command is abandoned and no `fin` is issued. A RAM write already committed at an earlier edge remains.
- `exec` rising on the first cycle after reset deasserts is accepted (`exec_q` is 0).
- `si_rdata` holds 0 outside ACK.

## Test plan
- Reset, then write 0xDEADBEEF to 0x104 → `fin` 2 cycles after the `exec` rise. Then `rd_addr`=1 → `rd_data`=0xDEADBEEF one cycle later. WR_COUNT reads 1.
- Hold `exec` high for 10 cycles with write to 0x108 → exactly one `fin`, and WR_COUNT increments by 1 only.
- Write 0x1FC → `frame_done` pulses in the same cycle as `fin`. Then write 0x100: no pulse; word 0 is updated (wrap-around).
- Misaligned write to 0x101, write to unmapped 0x010, and sample write after CTRL=0 → each receives `fin`, ERR_COUNT=3, and RAM is unchanged. Write to 0x008 → ERR_COUNT=0.
- Consumer reads word 5 while the SI write to 0x114 commits on the same edge → old value first, new value on the next cycle.
- Assert `reset` in the ACCESS cycle of a read of 0x00C → no `fin`. After reset, SCRATCH=0, CTRL=1, and all outputs are 0.
